// File: rtl/count_monitor_pkg.sv
// Shared types and constants for the count_monitor block.
// The wrap counter is enabled by the macro COUNT_MONITOR_WRAP_CNT_EN.
package count_monitor_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StDone
  } state_e;

  localparam logic [3:0]  CNT_MAX        = 4'hF;
  localparam int unsigned WRAP_W_DEFAULT = 8;

  // A wrap is only a rollover from the top count straight to zero.
  function automatic logic is_wrap(input logic       prev_vld,
                                   input logic [3:0] prev,
                                   input logic [3:0] cur);
    return prev_vld && (prev == CNT_MAX) && (cur == 4'h0);
  endfunction

endpackage

// File: rtl/count_edge_det.sv
// Tracks the previous upstream count and flags new values and 15->0 rollovers.
// Synchronous active-low reset.
module count_edge_det
  import count_monitor_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] q_i,
  output logic       new_val_o,
  output logic       wrap_det_o
);

  logic [3:0] q_q;
  logic       q_vld_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q     <= 4'h0;
      q_vld_q <= 1'b0;
    end else begin
      q_q     <= q_i;
      q_vld_q <= 1'b1;
    end
  end

  // Before the first sample every input counts as new, but never as a wrap.
  assign new_val_o  = !q_vld_q || (q_i != q_q);
  assign wrap_det_o = is_wrap(q_vld_q, q_q, q_i);

endmodule

// File: rtl/count_monitor.sv
// Compare/wrap monitor for an upstream 4-bit counter with an IDLE/ARMED/DONE FSM.
// Define COUNT_MONITOR_WRAP_CNT_EN to build the saturating wrap-event counter.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int unsigned WRAP_W = WRAP_W_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [3:0]        Q_IN,
  input  logic [3:0]        CMP_VAL,
  input  logic              CMP_LD,
  input  logic              ARM,
  input  logic              ONESHOT,
  input  logic              CLR,
  output logic              MATCH,
  output logic              IRQ,
  output logic              BUSY,
  output logic              WRAP,
  output logic [WRAP_W-1:0] WRAP_CNT
);

  state_e     state_q, state_d;
  logic [3:0] cmp_q, cmp_d;
  logic       match_q, match_d;
  logic       irq_q, irq_d;
  logic       busy_q, busy_d;
  logic       wrap_q, wrap_d;
  logic       new_val;
  logic       wrap_det;
  logic       match_hit;

  count_edge_det u_edge_det (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .q_i        (Q_IN),
    .new_val_o  (new_val),
    .wrap_det_o (wrap_det)
  );

  // Uses the registered compare value, so a same-cycle load only affects later cycles.
  assign match_hit = (state_q == StArmed) && new_val && (Q_IN == cmp_q);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (CLR) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (ARM) state_d = StArmed;
        StArmed: if (match_hit && ONESHOT) state_d = StDone;
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cmp_d   = CMP_LD ? CMP_VAL : cmp_q;
    match_d = match_hit;
    // A match in the clearing cycle still leaves the flag set.
    irq_d   = match_hit | (irq_q & ~CLR);
    busy_d  = (state_d == StArmed);
    wrap_d  = wrap_det;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cmp_q   <= 4'h0;
      match_q <= 1'b0;
      irq_q   <= 1'b0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      cmp_q   <= cmp_d;
      match_q <= match_d;
      irq_q   <= irq_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
    end
  end

  assign MATCH = match_q;
  assign IRQ   = irq_q;
  assign BUSY  = busy_q;
  assign WRAP  = wrap_q;

`ifdef COUNT_MONITOR_WRAP_CNT_EN
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

  // Clear restarts the count, but a wrap in the same cycle is kept as the first event.
  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (CLR) begin
      wrap_cnt_d = wrap_det ? WRAP_W'(1) : '0;
    end else if (wrap_det && (wrap_cnt_q != '1)) begin
      wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wrap_cnt_q <= '0;
    end else begin
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign WRAP_CNT = wrap_cnt_q;
`else
  assign WRAP_CNT = '0;
`endif

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter WRAP_W, default 8, sets the width of the wrap-event counter.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous, active-low reset, sampled on rising CLK.
REQ-004 Q_IN  input  4  count value from the upstream 4-bit counter, same CLK domain.
REQ-005 CMP_VAL  input  4  compare value, captured only when CMP_LD=1.
REQ-006 CMP_LD  input  1  load strobe for CMP_VAL.
REQ-007 ARM  input  1  arm request, level-sampled each cycle.
REQ-008 ONESHOT  input  1  1 = stop after first match; 0 = re-arm automatically.
REQ-009 CLR  input  1  clear: disarm, clear IRQ, clear WRAP_CNT.
REQ-010 MATCH  output  1  one-cycle match pulse.
REQ-011 IRQ  output  1  sticky match flag.
REQ-012 BUSY  output  1  high while state is ARMED.
REQ-013 WRAP  output  1  one-cycle pulse on a 15->0 transition of Q_IN.
REQ-014 WRAP_CNT  output  WRAP_W  saturating count of wrap events.

Function
REQ-015 The block SHALL register Q_IN into q_d each cycle and keep flag q_vld, set 1 after the first post-reset cycle.
REQ-016 "New value" SHALL mean q_vld=0 or Q_IN != q_d.
REQ-017 Wrap SHALL mean q_vld=1, q_d=4'hF and Q_IN=4'h0; any other drop to 0, such as an upstream reset, SHALL NOT count as a wrap.
REQ-018 WRAP SHALL assert exactly one cycle after the wrap condition.
REQ-019 WRAP_CNT SHALL increment on that same edge and saturate at all-ones.
REQ-020 CMP_LD=1 SHALL load cmp_reg from CMP_VAL; a compare evaluated in the same cycle uses the old cmp_reg.
REQ-021 FSM states SHALL be IDLE, ARMED and DONE.
REQ-022 IDLE -> ARMED on ARM=1 and CLR=0.
REQ-023 In ARMED, Q_IN = cmp_reg with a new value SHALL be a match; a stalled Q_IN SHALL NOT re-match.
REQ-024 A match SHALL assert MATCH one cycle later, set IRQ, and move to DONE if ONESHOT=1, else stay in ARMED.
REQ-025 ARM SHALL be ignored in ARMED and in DONE; only CLR exits DONE, to IDLE.
REQ-026 CLR=1 SHALL force the state to IDLE from any state and take priority over ARM.
REQ-027 A match and CLR in the same cycle SHALL still pulse MATCH and leave IRQ=1 (set wins over clear), with next state IDLE.
REQ-028 A wrap and CLR in the same cycle SHALL leave WRAP_CNT=1.
REQ-029 MATCH and WRAP SHALL be able to assert in the same cycle.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 While RST=0 at a rising edge: state=IDLE, cmp_reg=0, q_d=0, q_vld=0, MATCH=0, IRQ=0, BUSY=0, WRAP=0, WRAP_CNT=0.
REQ-032 Reset mid-operation SHALL abandon any pending match or wrap; the first cycle after reset never reports a wrap.

Configuration
REQ-033 Macro COUNT_MONITOR_WRAP_CNT_EN SHALL control the wrap counter.
REQ-034 With the macro defined, WRAP_CNT behaves per REQ-019 and REQ-028.
REQ-035 Without it, WRAP_CNT SHALL be tied to 0 and its register removed; WRAP and all other behaviour are unchanged.

Structure
REQ-036 Package count_monitor_pkg SHALL hold the FSM state enum (IDLE/ARMED/DONE), the constant CNT_MAX=4'hF and the default WRAP_W=8.
REQ-037 Sub-module count_edge_det SHALL hold q_d, q_vld and the new-value and wrap detection, exposing new_val and wrap_det to the top level.

Verification
REQ-038 Reset then ARM=1, cmp=5, ONESHOT=1, Q_IN ramps 0..15 -> MATCH pulse one cycle after Q_IN=5, IRQ=1, BUSY=0, state DONE.
REQ-039 ONESHOT=0, cmp=3, Q_IN ramps through two full wraps -> two MATCH pulses, two WRAP pulses, WRAP_CNT=2, BUSY stays 1.
REQ-040 Armed with cmp=7, Q_IN held at 7 for 5 cycles -> exactly one MATCH.
REQ-041 Q_IN 15->0 with CLR=1 in the same cycle and WRAP_CNT=9 -> WRAP pulse, WRAP_CNT=1, IRQ=0, state IDLE.
REQ-042 Q_IN 9->0 (upstream reset) -> no WRAP; WRAP_CNT unchanged.
REQ-043 Macro undefined, 20 wraps -> WRAP_CNT=0 throughout, 20 WRAP pulses.
